// File: rtl/booth_multiplier_seq.sv
// rtl/booth_multiplier_seq.sv - sequential radix-2 Booth signed multiplier, one step per clock
// The adder/subtractor is the only arithmetic element; the FSM sequences it.

module adder_subtractor_nbit #(
  parameter int n = 4
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         add_n,
  output logic [n-1:0] s,
  output logic         c_out,
  output logic         overflow
);
  logic [n-1:0] w_y;
  logic [n:0]   w_full;

  assign w_y      = y ^ {n{add_n}};
  assign w_full   = {1'b0, x} + {1'b0, w_y} + {{n{1'b0}}, add_n};
  assign s        = w_full[n-1:0];
  assign c_out    = w_full[n];
  assign overflow = (x[n-1] == w_y[n-1]) && (s[n-1] != x[n-1]);
endmodule

module booth_multiplier_seq #(
  parameter int n = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [n-1:0]   multiplicand,
  input  logic [n-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*n-1:0] product
);
  localparam int CW = $clog2(n) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t         r_state, w_next;
  logic [n:0]     r_a, r_mx;
  logic [n-1:0]   r_q;
  logic           r_qm1;
  logic [CW-1:0]  r_cnt;
  logic [2*n-1:0] r_product;

  logic           w_load, w_finish;
  logic [n:0]     w_sum, w_a_new, w_a_sh;
  logic [n-1:0]   w_q_sh;
  logic           w_unused_c_out, w_unused_ovf;

  // Subtract on a 1->0 Booth transition (10), add on 0->1 (01).
  adder_subtractor_nbit #(.n(n+1)) u_addsub (
    .x        (r_a),
    .y        (r_mx),
    .add_n    (r_q[0] & ~r_qm1),
    .s        (w_sum),
    .c_out    (w_unused_c_out),
    .overflow (w_unused_ovf)
  );

  assign w_a_new = (r_q[0] ^ r_qm1) ? w_sum : r_a;
  assign w_a_sh  = {w_a_new[n], w_a_new[n:1]};
  assign w_q_sh  = {w_a_new[0], r_q[n-1:1]};
  assign product = r_product;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    done     = 1'b0;
    w_load   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (r_cnt == '0) begin
          w_finish = 1'b1;
          w_next   = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_load = 1'b1;
          w_next = S_CALC;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a       <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_mx      <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_load) begin
      r_a   <= '0;
      r_q   <= multiplier;
      r_qm1 <= 1'b0;
      r_mx  <= {multiplicand[n-1], multiplicand};
      r_cnt <= CW'(n - 1);
    end else if (r_state == S_CALC) begin
      r_a   <= w_a_sh;
      r_q   <= w_q_sh;
      r_qm1 <= r_q[0];
      if (w_finish) r_product <= {w_a_sh[n-1:0], w_q_sh};
      else          r_cnt     <= r_cnt - CW'(1);
    end
  end
endmodule

// File: tb/tb_booth_multiplier_seq.sv
// tb/tb_booth_multiplier_seq.sv - directed-vector bench for booth_multiplier_seq (n=4 and n=8)
module tb_booth_multiplier_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start4 = 1'b0, start8 = 1'b0;
  logic [3:0]  m4 = '0, q4 = '0;
  logic [7:0]  m8 = '0, q8 = '0;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  prod4;
  logic [15:0] prod8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  booth_multiplier_seq #(.n(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .multiplicand(m4), .multiplier(q4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  booth_multiplier_seq #(.n(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .multiplicand(m8), .multiplier(q8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated multiply from IDLE; checks busy length, latency, result and done width.
  task automatic do_mul(input int w, input logic [7:0] m, input logic [7:0] q,
                        input logic [15:0] exp, input string tag);
    int k, nb;
    logic bsy, dn;
    @(negedge clk);
    if (w == 4) begin start4 = 1'b1; m4 = m[3:0]; q4 = q[3:0]; end
    else        begin start8 = 1'b1; m8 = m;      q8 = q;      end
    @(posedge clk);
    #1;
    start4 = 1'b0;
    start8 = 1'b0;
    k  = 0;
    nb = 0;
    dn = 1'b0;
    while (!dn && k < 40) begin
      @(negedge clk);
      k++;
      bsy = (w == 4) ? busy4 : busy8;
      dn  = (w == 4) ? done4 : done8;
      if (bsy) nb++;
    end
    check({tag, "_latency"}, k - 1, w);
    check({tag, "_busy_cycles"}, nb, w);
    check({tag, "_product"}, (w == 4) ? {8'h0, prod4} : prod8, exp);
    @(negedge clk);
    check({tag, "_done_fall"}, (w == 4) ? done4 : done8, 1'b0);
    check({tag, "_product_hold"}, (w == 4) ? {8'h0, prod4} : prod8, exp);
  endtask

  initial begin
    int k, ndone;
    logic [7:0] cap;
    logic signed [3:0] sm, sq;
    logic [7:0] expv;

    #12;
    check("reset_busy", busy4, 1'b0);
    check("reset_done", done4, 1'b0);
    check("reset_product", prod4, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    do_mul(4, 8'h03, 8'h05, 16'h000F, "m3x5");
    do_mul(4, 8'h08, 8'h08, 16'h0040, "mneg8xneg8");
    do_mul(4, 8'h08, 8'h07, 16'h00C8, "mneg8x7");
    do_mul(4, 8'h07, 8'h0F, 16'h00F9, "m7xneg1");

    // start re-asserted during the second CALC cycle must be ignored
    @(negedge clk);
    start4 = 1'b1; m4 = 4'd3; q4 = 4'd5;
    @(posedge clk);
    #1 start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start4 = 1'b1; m4 = 4'd6; q4 = 4'd6;
    @(negedge clk);
    start4 = 1'b0;
    ndone = 0;
    cap = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done4) begin ndone++; cap = prod4; end
    end
    check("ignore_done_count", ndone, 1);
    check("ignore_product", cap, 8'h0F);

    // exhaustive back-to-back sweep with start held high
    for (int i = 0; i < 256; i++) begin
      sm = i[7:4];
      sq = i[3:0];
      expv = 8'(sm * sq);
      start4 = 1'b1;
      m4 = i[7:4];
      q4 = i[3:0];
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!done4 && k < 20);
      check("sweep_gap", k, 5);
      check("sweep_product", prod4, expv);
    end
    start4 = 1'b0;
    repeat (2) @(negedge clk);
    check("sweep_end_idle", {busy4, done4}, 2'b00);

    do_mul(8, 8'h80, 8'h80, 16'h4000, "n8_neg128sq");
    do_mul(8, 8'h7F, 8'h80, 16'hC080, "n8_127xneg128");

    // asynchronous reset between clock edges during CALC
    @(negedge clk);
    start4 = 1'b1; m4 = 4'd7; q4 = 4'd7;
    @(posedge clk);
    #1 start4 = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("abort_busy", busy4, 1'b0);
    check("abort_done", done4, 1'b0);
    check("abort_product", prod4, 8'h00);
    check("abort_product_n8", prod8, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    check("abort_no_done", ndone, 0);
    do_mul(4, 8'h02, 8'h0D, 16'h00FA, "m2xneg3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/booth_multiplier_seq.md
# booth_multiplier_seq

Sequential signed (two's-complement) n×n → 2n-bit multiplier using the radix-2 Booth algorithm. A single `adder_subtractor_nbit` instance performs every add or subtract, so the block is a controller that sequences that datapath: one Booth step per clock. It sits beside the calculator's combinational add/sub path and provides the multiply operation.

## Interface
- `n`, default 4, operand width in bits; `n >= 2`.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high; clears the FSM and all outputs.
- `start`  input  1  request a multiply; sampled only in IDLE or DONE.
- `multiplicand`  input  n  signed operand M; latched when `start` is accepted.
- `multiplier`  input  n  signed operand Q; latched when `start` is accepted.
- `busy`  output  1  high while in CALC.
- `done`  output  1  one-cycle pulse; marks the cycle in which `product` first holds a new result.
- `product`  output  2n  signed result M×Q; holds its value until the next result is written.

## Operation
- Datapath registers:
  - A, n+1 bits: accumulator, with one guard bit so the -2^(n-1) operand cannot overflow.
  - Q, n bits: multiplier / low product.
  - q_m1, 1 bit: Booth history bit.
  - Mx, n+1 bits: the multiplicand sign-extended by one bit.
  - cnt: a down-counter of width clog2(n)+1.
- Adder: one `adder_subtractor_nbit #(.n(n+1))` instance.
  - x = A, y = Mx.
  - add_n = 1 for subtract, 0 for add.
  - c_out and overflow are left unused; the guard bit makes overflow impossible.
- FSM states: IDLE, CALC, DONE.
  - IDLE: `busy`=0, `done`=0. On `start`=1: load A=0, Q=multiplier, q_m1=0, Mx=sext(multiplicand), cnt=n-1, then go to CALC.
  - CALC: `busy`=1. Each cycle, select by {Q[0], q_m1}:
    - 10: A ← A − Mx.
    - 01: A ← A + Mx.
    - 00 / 11: A unchanged.
  - CALC, same cycle: arithmetic-shift {A_new, Q, q_m1} right by 1, replicating A_new's MSB.
  - CALC exit: when cnt=0, write `product` ← low 2n bits of {A_shifted, Q_shifted} and go to DONE. Otherwise cnt ← cnt−1.
  - DONE: `done`=1, `busy`=0, for exactly one cycle.
    - `start`=1: reload exactly as in IDLE and go to CALC (back-to-back operation).
    - Otherwise: go to IDLE.
- `start` is ignored while in CALC. Operand inputs may change freely after acceptance.
- `product` changes only on the CALC→DONE transition and on reset.
- Result width: full 2n-bit signed product. No truncation or saturation; every input pair, including (-2^(n-1))², is exact.

## Timing
- Reset (asynchronous, any time, including mid-CALC): state=IDLE, `busy`=0, `done`=0, `product`=0, A/Q/q_m1/Mx/cnt=0. No `done` pulse is produced for the aborted operation.
- Start accepted at rising edge T0. `busy` is high from T0 through T0+n; CALC occupies n cycles.
- `done` is high and `product` valid at T0+n; `done` falls at T0+n+1.
- `product` stays valid after `done` until the next completion.
- Latency is fixed at n cycles from accepting edge to `done`, independent of operand values.
- Throughput: with `start` held high in DONE, one result every n+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- n=4, reset released, `start` pulse with M=3, Q=5 → `busy` high for 4 cycles; `done` pulses 4 cycles after the accepting edge; `product`=8'h0F.
- n=4, M=-8 (4'h8), Q=-8 → `product`=8'h40 (+64). This checks the guard bit; without it the result would be wrong. Also M=-8, Q=7 → 8'hC8 (-56); M=7, Q=-1 → 8'hF9.
- n=4, exhaustive sweep of all 256 operand pairs, back-to-back with `start` held high → each `product` equals the signed reference product; one `done` every 5 cycles.
- `start` re-asserted with new operands in the 2nd CALC cycle of 3×5 → ignored; result remains 8'h0F, with a single `done`.
- Assert `reset` asynchronously mid-CALC (between clock edges) → `busy`, `done` and `product` go to 0 immediately. A subsequent 2×(-3) gives 8'hFA with normal latency.
- n=8 instance, M=-128, Q=-128 → `product`=16'h4000 after 8 CALC cycles; M=127, Q=-128 → 16'hC080.
